// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave that fronts the single-port RAM.
package spi_pkg;

    localparam int RX_W_DEF = 10;
    localparam int TX_W_DEF = 8;

    // Top two bits of every received word tell the RAM what to do with it
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    function automatic logic is_data_state(input state_t s);
        return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
    endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// Serial-to-parallel shifter: collects RX_W MOSI bits MSB first and strobes the word out once.
module spi_rx_shifter #(
    parameter int RX_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    input  logic            mosi,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    output logic            word_done
);

    localparam logic [3:0] LAST_CNT = 4'(RX_W);
    localparam logic [3:0] DONE_CNT = 4'(RX_W + 1);

    logic [RX_W-1:0] shift_q;
    logic [3:0]      bit_cnt;

    assign word_done = enable && !clear && (bit_cnt == LAST_CNT);

    // Counter parks at DONE_CNT after the strobe so a held frame never re-strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (clear) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (enable) begin
                if (bit_cnt < LAST_CNT) begin
                    shift_q <= {shift_q[RX_W-2:0], mosi};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == LAST_CNT) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                    bit_cnt  <= DONE_CNT;
                end
            end
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for a single-port RAM: command decode FSM, read-address
// tracking and MISO serialisation of the byte the RAM returns.
module spi_slave
    import spi_pkg::*;
#(
    parameter int RX_W = RX_W_DEF,
    parameter int TX_W = TX_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam int              TXC_W   = $clog2(TX_W + 1);
    localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(TX_W);

    state_t            state;
    logic              rd_addr_flag;
    logic [TX_W-1:0]   tx_byte;
    logic [TXC_W-1:0]  tx_cnt;
    logic              waiting;
    logic              sending;
    logic              shift_en;
    logic              shift_clr;
    logic              word_done;

    assign shift_en  = is_data_state(state);
    assign shift_clr = SS_n || !is_data_state(state);

    spi_rx_shifter #(
        .RX_W(RX_W)
    ) u_rx_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (shift_clr),
        .enable   (shift_en),
        .mosi     (MOSI),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .word_done(word_done)
    );

    // Deselect ends any frame; the read flag only drops if the byte fully went out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_addr_flag <= 1'b0;
            tx_byte      <= '0;
            tx_cnt       <= '0;
            waiting      <= 1'b0;
            sending      <= 1'b0;
            MISO         <= 1'b0;
        end else if (SS_n) begin
            if (sending && (tx_cnt == TX_LAST)) begin
                rd_addr_flag <= 1'b0;
            end
            state   <= IDLE;
            tx_cnt  <= '0;
            waiting <= 1'b0;
            sending <= 1'b0;
            MISO    <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI) begin
                        state <= WRITE;
                    end else if (rd_addr_flag) begin
                        state <= READ_DATA;
                    end else begin
                        state <= READ_ADD;
                    end
                end
                WRITE: begin
                end
                READ_ADD: begin
                    if (word_done) begin
                        rd_addr_flag <= 1'b1;
                    end
                end
                READ_DATA: begin
                    // MSB goes out straight from tx_data so it appears the cycle after capture
                    if (word_done) begin
                        waiting <= 1'b1;
                    end else if (waiting && tx_valid) begin
                        tx_byte <= tx_data;
                        MISO    <= tx_data[TX_W-1];
                        tx_cnt  <= TXC_W'(1);
                        waiting <= 1'b0;
                        sending <= 1'b1;
                    end else if (sending) begin
                        if (tx_cnt != TX_LAST) begin
                            MISO    <= tx_byte[TX_W-2];
                            tx_byte <= tx_byte << 1;
                            tx_cnt  <= tx_cnt + TXC_W'(1);
                        end else begin
                            MISO         <= 1'b0;
                            sending      <= 1'b0;
                            rd_addr_flag <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a frame-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int RX_W = 10;
    localparam int TX_W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            SS_n;
    logic            MOSI;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int frame_start = 0;

    spi_slave #(
        .RX_W(RX_W),
        .TX_W(TX_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s at cycle %0d: timed out waiting for rx_valid", name, cyc);
    endtask

    // Reference model: tracks the frame by position (awaiting command, bits received)
    // and the read reply as a queue of bits still to appear on MISO.
    bit              m_in_frame = 0;
    bit              m_cmd_next = 0;
    int              m_pos = 0;
    int              m_kind = 0;
    logic [RX_W-1:0] m_word = '0;
    logic [RX_W-1:0] m_rx_data = '0;
    bit              m_rx_valid = 0;
    bit              m_flag = 0;
    bit              m_wait = 0;
    bit              m_sending = 0;
    bit              m_miso = 0;
    bit              miso_q[$];

    always @(posedge clk) begin
        m_rx_valid = 0;
        if (!rst_n) begin
            m_in_frame = 0; m_cmd_next = 0; m_pos = 0; m_word = '0; m_rx_data = '0;
            m_flag = 0; m_wait = 0; m_sending = 0; m_miso = 0; miso_q.delete();
        end else if (SS_n) begin
            if (m_sending && miso_q.size() == 0) m_flag = 0;
            m_in_frame = 0; m_cmd_next = 0; m_pos = 0; m_word = '0;
            m_wait = 0; m_sending = 0; m_miso = 0; miso_q.delete();
        end else if (!m_in_frame) begin
            m_in_frame = 1;
            m_cmd_next = 1;
        end else if (m_cmd_next) begin
            m_cmd_next = 0;
            m_kind = !MOSI ? 0 : (m_flag ? 2 : 1);
            m_pos = 0;
        end else if (m_pos < RX_W) begin
            m_word = RX_W'((m_word * 2) + MOSI);
            m_pos++;
        end else if (m_pos == RX_W) begin
            m_rx_data = m_word;
            m_rx_valid = 1;
            m_pos++;
            if (m_kind == 1) m_flag = 1;
            if (m_kind == 2) m_wait = 1;
        end else if (m_wait && tx_valid) begin
            for (int i = TX_W - 1; i >= 0; i--) miso_q.push_back(tx_data[i]);
            m_miso = miso_q.pop_front();
            m_wait = 0;
            m_sending = 1;
        end else if (m_sending) begin
            if (miso_q.size() > 0) begin
                m_miso = miso_q.pop_front();
            end else begin
                m_miso = 0;
                m_sending = 0;
                m_flag = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check_output("cyc_rx_valid", rx_valid, m_rx_valid);
            check_output("cyc_rx_data", rx_data, m_rx_data);
            check_output("cyc_miso", MISO, m_miso);
            check_output("cyc_flag", dut.rd_addr_flag, m_flag);
            check_output("cyc_idle", dut.state == IDLE, !m_in_frame);
        end
    end

    // Drops SS_n, sends the command bit, then nbits of word MSB first
    task automatic apply_stimulus(input logic cmd, input logic [RX_W-1:0] word,
                                  input int nbits, input logic spur);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        frame_start = cyc;
        @(negedge clk);
        MOSI = cmd;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            MOSI = word[RX_W-1-i];
            if (spur) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
        end
    endtask

    task automatic wait_strobe(output int lat);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            MOSI = 1'b0;
            tx_valid = 1'b0;
            if (rx_valid) begin
                lat = cyc - frame_start - 1;
                break;
            end
        end
        if (lat < 0) fail_now("strobe_timeout");
    endtask

    task automatic end_frame();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    int              lat;
    int              pulses;
    logic            miso_seen;
    logic [TX_W-1:0] bits;

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        check_output("rst_rx_data", rx_data, 10'h000);
        check_output("rst_rx_valid", rx_valid, 1'b0);
        check_output("rst_miso", MISO, 1'b0);
        check_output("rst_flag", dut.rd_addr_flag, 1'b0);
        check_output("rst_state_idle", dut.state == IDLE, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Write address 0x005
        apply_stimulus(1'b0, 10'h005, 10, 1'b0);
        wait_strobe(lat);
        check_output("wa_latency", lat, 12);
        check_output("wa_rx_data", rx_data, 10'h005);
        @(negedge clk);
        check_output("wa_rx_valid_drop", rx_valid, 1'b0);
        end_frame();

        // Write data 0x1AA with a spurious tx_valid throughout
        apply_stimulus(1'b0, 10'h1AA, 10, 1'b1);
        wait_strobe(lat);
        check_output("wd_rx_data", rx_data, 10'h1AA);
        pulses = 1;
        miso_seen = 1'b0;
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        repeat (4) begin
            @(negedge clk);
            if (rx_valid) pulses++;
            miso_seen = miso_seen | MISO;
        end
        tx_valid = 1'b0;
        check_output("wd_single_pulse", pulses, 1);
        check_output("wd_miso_quiet", miso_seen, 1'b0);
        check_output("wd_state_write", dut.state == WRITE, 1'b1);
        end_frame();

        // Read: address frame then data frame returning 0xC3
        apply_stimulus(1'b1, 10'h205, 10, 1'b0);
        wait_strobe(lat);
        check_output("ra_rx_data", rx_data, 10'h205);
        @(negedge clk);
        check_output("ra_flag_set", dut.rd_addr_flag, 1'b1);
        end_frame();
        apply_stimulus(1'b1, 10'h300, 10, 1'b0);
        wait_strobe(lat);
        check_output("rd_rx_data", rx_data, 10'h300);
        check_output("rd_state", dut.state == READ_DATA, 1'b1);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = '0;
        bits[7] = MISO;
        for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            bits[i] = MISO;
        end
        check_output("rd_miso_byte", bits, 8'hC3);
        @(negedge clk);
        check_output("rd_miso_after", MISO, 1'b0);
        check_output("rd_flag_clear", dut.rd_addr_flag, 1'b0);
        end_frame();

        // Abort after five data bits, then a clean frame
        apply_stimulus(1'b0, 10'h3FF, 5, 1'b0);
        @(negedge clk);
        SS_n = 1'b1;
        @(negedge clk);
        check_output("ab_state_idle", dut.state == IDLE, 1'b1);
        check_output("ab_no_strobe", rx_valid, 1'b0);
        check_output("ab_rx_data_held", rx_data, 10'h300);
        apply_stimulus(1'b0, 10'h2C3, 10, 1'b0);
        wait_strobe(lat);
        check_output("ab_next_rx_data", rx_data, 10'h2C3);
        end_frame();

        // Deselect during the wait phase keeps the read flag
        apply_stimulus(1'b1, 10'h207, 10, 1'b0);
        wait_strobe(lat);
        end_frame();
        apply_stimulus(1'b1, 10'h3AA, 10, 1'b0);
        wait_strobe(lat);
        @(negedge clk);
        SS_n = 1'b1;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        @(negedge clk);
        tx_valid = 1'b0;
        check_output("wt_flag_kept", dut.rd_addr_flag, 1'b1);
        check_output("wt_miso_quiet", MISO, 1'b0);

        // Reset in the middle of the MISO transfer
        apply_stimulus(1'b1, 10'h301, 10, 1'b0);
        wait_strobe(lat);
        check_output("rr_state", dut.state == READ_DATA, 1'b1);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'h96;
        @(negedge clk);
        tx_valid = 1'b0;
        check_output("rr_first_bit", MISO, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("rr_rx_data", rx_data, 10'h000);
        check_output("rr_rx_valid", rx_valid, 1'b0);
        check_output("rr_miso", MISO, 1'b0);
        check_output("rr_flag", dut.rd_addr_flag, 1'b0);
        check_output("rr_state_idle", dut.state == IDLE, 1'b1);
        rst_n = 1'b1;
        SS_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
